// File: rtl/uart_ctrl_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_ctrl_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 20000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: nearest requester above last_winner, with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_winner,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Walk from farthest to nearest so the nearest hit overwrites earlier ones.
  always_comb begin
    logic [IDX_W-1:0] w_idx;
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(last_winner) + k) % NUM_REQ);
      if (req[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional start-acknowledge watchdog with timeout_err output: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk_100m,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  active_id,
  output logic                        arb_idle
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [IDX_W-1:0]  r_last_winner;
  logic [IDX_W-1:0]  r_active_id;
  logic [DATA_W-1:0] r_tx_data;
  logic [IDX_W-1:0]  w_pick;
  logic              w_pick_vld;
  logic              w_grant_fire;
  logic [DATA_W-1:0] w_pick_data;
  logic              w_to_expire;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req         (req),
    .last_winner (r_last_winner),
    .winner      (w_pick),
    .valid       (w_pick_vld)
  );

  assign w_pick_data = req_data[w_pick*DATA_W +: DATA_W];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  assign w_to_expire = (r_state == ST_START) && !tx_busy && (r_to_cnt == TO_LAST);

  // Counts START cycles only; cleared whenever START is left or not yet entered.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_to_expire;
      if (r_state == ST_START && w_state_nxt == ST_START) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_to_expire = 1'b0;
`endif

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tx_data     <= '0;
      r_active_id   <= '0;
      r_last_winner <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_fire) begin
        r_tx_data     <= w_pick_data;
        r_active_id   <= w_pick;
        r_last_winner <= w_pick;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_fire = 1'b0;
    grant        = '0;
    case (r_state)
      ST_IDLE: begin
        // A foreign transfer holding tx_busy blocks the launch.
        if (w_pick_vld && !tx_busy) begin
          w_grant_fire = 1'b1;
          w_state_nxt  = ST_START;
        end
      end
      ST_START: begin
        if (tx_busy) begin
          w_state_nxt = ST_BUSY;
        end else if (w_to_expire) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_BUSY: begin
        if (!tx_busy) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // The grant pulse is Mealy, so it is also masked while reset is held.
    if (w_grant_fire && !rst) begin
      grant[w_pick] = 1'b1;
    end
  end

  assign tx_start  = (r_state == ST_START);
  assign arb_idle  = (r_state == ST_IDLE);
  assign tx_data   = r_tx_data;
  assign active_id = r_active_id;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4; number of requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter DATA_W, default 8; byte width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 20000; start-acknowledge watchdog limit in clk_100m cycles.
REQ-004 SHALL have port clk_100m  input  1  the single system clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester level request; byte pending.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port grant  output  NUM_REQ  one-hot, one-cycle pulse; requester's byte accepted.
REQ-009 SHALL have port tx_data  output  DATA_W  byte to the transmitter's data_in.
REQ-010 SHALL have port tx_start  output  1  drives the transmitter's En_btn.
REQ-011 SHALL have port tx_busy  input  1  the transmitter's tx_busy.
REQ-012 SHALL have port active_id  output  $clog2(NUM_REQ)  index of the requester being served.
REQ-013 SHALL have port arb_idle  output  1  high only in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, START, BUSY, GAP.
REQ-015 IDLE: if any req bit is high and tx_busy=0, SHALL pick a winner round-robin, latch its byte into tx_data, set active_id, pulse grant[winner] for exactly that cycle, and go to START.
REQ-016 Round-robin SHALL search from index (last_winner+1) mod NUM_REQ upward with wrap-around; after reset last_winner=NUM_REQ-1, so index 0 has first priority.
REQ-017 IDLE with tx_busy=1 SHALL NOT launch; it waits until tx_busy=0 (foreign transfer in flight).
REQ-018 START: tx_start SHALL be 1; on tx_busy=1 go to BUSY and drop tx_start the next cycle.
REQ-019 BUSY: tx_start=0; on tx_busy=0 go to GAP.
REQ-020 GAP: SHALL last exactly one cycle, then IDLE; no grant issued in GAP.
REQ-021 tx_data and active_id SHALL stay stable from grant until the next grant.
REQ-022 Requester may change req_data or drop req from the cycle after its grant; a req dropped before it is granted SHALL be ignored.
REQ-023 Grant-to-tx_start latency SHALL be 1 cycle (tx_start high in the cycle after the grant pulse).
REQ-024 Minimum spacing between consecutive grants SHALL be 4 cycles (IDLE, START, BUSY, GAP).
REQ-025 At most one grant bit SHALL be high in any cycle.

Reset
REQ-026 While rst=1, SHALL force state IDLE, grant=0, tx_start=0, tx_data=0, active_id=0, arb_idle=1, and last_winner=NUM_REQ-1, independent of clk_100m.
REQ-027 Reset mid-transfer SHALL abandon the in-flight byte without a re-grant; arbitration after release starts from index 0.

Configuration
REQ-028 SHALL support macro UART_ARB_TIMEOUT_EN.
REQ-029 With UART_ARB_TIMEOUT_EN defined:
- add output timeout_err (1 bit).
- a counter SHALL run in START only.
- if tx_busy is not seen within TIMEOUT_CYC cycles, SHALL drop tx_start, pulse timeout_err for one cycle, and go to GAP; the byte is discarded.
- timeout_err SHALL reset to 0.
REQ-030 Without UART_ARB_TIMEOUT_EN:
- no timeout_err port and no counter.
- START SHALL wait indefinitely.

Structure
REQ-031 Package uart_ctrl_pkg SHALL hold the FSM state enum (arb_state_t) and default constants for NUM_REQ, DATA_W and TIMEOUT_CYC.
REQ-032 Round-robin search SHALL be a combinational sub-module rr_pick with inputs req and last_winner and outputs winner and valid; it is instantiated once.

Verification
REQ-033 Single request: req=4'b0100 with byte 8'hA5 on lane 2, tx_busy model rising 2 cycles after tx_start -> grant=4'b0100 for one cycle, tx_data=8'hA5, tx_start next cycle, active_id=2.
REQ-034 Fairness: req=4'b1111 held for 8 bytes -> grant order 0,1,2,3,0,1,2,3, spacing >=4 cycles, never two grant bits at once.
REQ-035 Busy blocking: tx_busy=1 held externally while req=4'b0001 -> no grant until tx_busy falls, then grant within 1 cycle.
REQ-036 Reset mid-BUSY: assert rst while tx_busy=1 -> tx_start=0, arb_idle=1 immediately (asynchronous); after release, req=4'b1010 -> lane 1 granted first.
REQ-037 Timeout (UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, tx_busy stuck at 0): after grant -> tx_start high 16 cycles, one-cycle timeout_err pulse, GAP, IDLE; next request served normally.
